i2c_bus_arbiter: RTL and testbench
==================================

# i2c_bus_arbiter

Shares the single ADV7513/camera I2C master between multiple transaction sources (power-up init sequencer, user register reader, camera configuration). It sits between those requesters and the I2C master's command port. It grants one requester at a time using round-robin priority, and enforces a minimum idle gap between transactions. It also applies a watchdog timeout so a hung transaction cannot lock the bus.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- GAP_CYCLES, 600, idle clk cycles forced between consecutive transactions (0 allowed).
- TIMEOUT_CYCLES, 1000000, max clk cycles from m_start to m_done before abort (≥ 2).

Ports:
- clk  in  1  system clock (50 MHz domain of the I2C master).
- reset  in  1  asynchronous, active-high; all state cleared immediately.
- req  in  NUM_REQ  level request per requester; held until its done pulse.
- req_rw  in  NUM_REQ  1 = read, 0 = write, per requester.
- req_chip_addr  in  7*NUM_REQ  7-bit device address, requester i at [7i+6:7i].
- req_reg_addr  in  8*NUM_REQ  register address, requester i at [8i+7:8i].
- req_wdata  in  8*NUM_REQ  write data, requester i at [8i+7:8i].
- grant  out  NUM_REQ  one-hot owner of the current transaction; 0 when idle.
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- err  out  1  valid with done; 1 = NACK or timeout.
- rdata  out  8  read data, valid with done and held until the next done.
- busy  out  1  high in every state except IDLE.
- m_start  out  1  one-cycle command strobe to the I2C master.
- m_rw, m_chip_addr[6:0], m_reg_addr[7:0], m_wdata[7:0]  out  command fields, stable from m_start until m_done or abort.
- m_abort  out  1  one-cycle pulse on timeout; returns the master to idle.
- m_done  in  1  one-cycle master completion pulse.
- m_ack_err  in  1  NACK flag, valid with m_done.
- m_rdata  in  8  master read data, valid with m_done.

## Operation
- States: IDLE, ISSUE, WAIT, GAP.
- IDLE: when any req bit is set, pick the winner by round-robin. The search starts at (last+1) mod NUM_REQ and takes the first set bit. Register grant, latch that requester's command fields onto m_*, set last = winner, go to ISSUE.
- ISSUE: m_start = 1 for exactly one cycle, clear the timeout counter, go to WAIT.
- WAIT: the timeout counter increments each cycle.
  - On m_done: pulse done[winner], set err = m_ack_err, and latch rdata = m_rdata only if m_rw = 1 (otherwise rdata is unchanged). Go to GAP.
  - If the counter reaches TIMEOUT_CYCLES-1 without m_done: pulse m_abort and done[winner] with err = 1, leave rdata unchanged, go to GAP.
  - m_done and timeout in the same cycle: m_done wins and m_abort is not pulsed.
- GAP: grant is cleared and the gap counter runs for GAP_CYCLES cycles, then the state returns to IDLE. With GAP_CYCLES = 0, GAP lasts one cycle.
- Requester contract: drop req within GAP_CYCLES cycles of done. A req still high on return to IDLE is a new request.
- Request changes while granted: a req drop or command-field change has no effect; fields are latched in IDLE. m_done seen outside WAIT is ignored.
- last resets to NUM_REQ-1, so requester 0 has first priority after reset.
- Counters are 32 bits wide and saturate; they never wrap.

## Timing
- Reset values: grant = 0, done = 0, err = 0, rdata = 8'h00, busy = 0, m_start = 0, m_abort = 0, and all m_* command fields = 0. State = IDLE.
- Reset mid-transaction returns every output to its reset value asynchronously. No done or m_abort is generated, because the master shares the same reset.
- Latency from req rising (sampled in IDLE at edge N):
  - grant and m_* fields valid after edge N.
  - m_start high between edges N+1 and N+2.
- done/err/rdata are registered one cycle after the m_done cycle.
- Back-to-back throughput per transaction: 2 + master time + 1 + GAP_CYCLES cycles.
- Outputs are registered; no combinational path from req or m_* inputs to any output.

## Test plan
- Single write: req[0] set, chip 7'h39, reg 8'h41, wdata 8'h10, master returns m_done after 100 cycles with no NACK.
  - Expect m_start once, m_* fields equal to the request, done[0] with err = 0, rdata unchanged, busy low 600+1 cycles after done.
- Read: req[1] set with rw = 1 and reg 8'h42; master returns m_rdata = 8'h5A.
  - Expect rdata = 8'h5A and err = 0 with done[1], and grant = 2'b10 throughout.
- Contention: req = 2'b11 asserted at the same cycle from reset.
  - Expect order 0, 1. Then with both held high, order alternates 0, 1, 0, 1, never two grants to the same requester while the other waits.
- NACK: master returns m_ack_err = 1.
  - Expect done with err = 1, then the next requester is served after the gap.
- Timeout: TIMEOUT_CYCLES = 50 and the master never responds.
  - Expect m_abort and done/err = 1 exactly 50 cycles after m_start.
  - In a second run, m_done arrives on the timeout cycle: expect err = m_ack_err and no m_abort.
- Reset mid-WAIT: assert reset 20 cycles after m_start.
  - Expect all outputs at their reset values immediately.
  - After release, expect requester 0 to win a pending 2'b11 contention.

Source files
------------

// File: rtl/i2c_bus_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_bus_arbiter
//
// Shares one I2C master command port between NUM_REQ transaction sources
// (init sequencer, register reader, camera configuration). One requester is
// served at a time in round-robin order. A forced idle gap separates
// consecutive transactions, and a watchdog aborts a transaction whose master
// never reports completion.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   req               level request per requester (held until its done)
//   req_rw            per-requester direction, 1 = read
//   req_chip_addr     7-bit device address, requester i at [7i+6:7i]
//   req_reg_addr      8-bit register address, requester i at [8i+7:8i]
//   req_wdata         8-bit write data, requester i at [8i+7:8i]
//   grant             one-hot owner of the current transaction, 0 when idle
//   done              one-cycle completion pulse to the owner
//   err               valid with done: NACK or watchdog abort
//   rdata             read data, valid with done, held until the next done
//   busy              high whenever the arbiter is not idle
//   m_start           one-cycle command strobe to the I2C master
//   m_rw, m_chip_addr, m_reg_addr, m_wdata   latched command fields
//   m_abort           one-cycle pulse returning a hung master to idle
//   m_done            master completion pulse
//   m_ack_err         master NACK flag, valid with m_done
//   m_rdata           master read data, valid with m_done
// ---------------------------------------------------------------------------
module i2c_bus_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int GAP_CYCLES     = 600,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_rw,
    input  logic [7*NUM_REQ-1:0]   req_chip_addr,
    input  logic [8*NUM_REQ-1:0]   req_reg_addr,
    input  logic [8*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic                   err,
    output logic [7:0]             rdata,
    output logic                   busy,
    output logic                   m_start,
    output logic                   m_rw,
    output logic [6:0]             m_chip_addr,
    output logic [7:0]             m_reg_addr,
    output logic [7:0]             m_wdata,
    output logic                   m_abort,
    input  logic                   m_done,
    input  logic                   m_ack_err,
    input  logic [7:0]             m_rdata
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    // Terminal counts; a zero gap still spends one cycle in GAP.
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] GAP_LAST = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'd0;
    localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

    localparam logic [IW:0]        NUM_REQ_W = (IW + 1)'(NUM_REQ);
    localparam logic [IW-1:0]      LAST_RST  = IW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0  = {{(NUM_REQ - 1){1'b0}}, 1'b1};

    // State and registered outputs
    logic [1:0]         state_q, state_d;
    logic [IW-1:0]      last_q, last_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               err_q, err_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               busy_q, busy_d;
    logic               m_start_q, m_start_d;
    logic               m_abort_q, m_abort_d;
    logic               m_rw_q, m_rw_d;
    logic [6:0]         m_chip_addr_q, m_chip_addr_d;
    logic [7:0]         m_reg_addr_q, m_reg_addr_d;
    logic [7:0]         m_wdata_q, m_wdata_d;
    logic [31:0]        tmo_cnt_q, tmo_cnt_d;
    logic [31:0]        gap_cnt_q, gap_cnt_d;

    // Arbitration results
    logic [IW-1:0]      win_s;
    logic               win_valid_s;
    logic [IW:0]        cand_sum_s;
    logic [IW:0]        cand_s;
    logic [NUM_REQ-1:0] win_onehot_s;
    logic               sel_rw_s;
    logic [6:0]         sel_chip_s;
    logic [7:0]         sel_reg_s;
    logic [7:0]         sel_wdata_s;

    // Round-robin search: scan from last+1 (wrapping) and take the first set request.
    always_comb begin
        win_s       = last_q;
        win_valid_s = 1'b0;
        cand_sum_s  = '0;
        cand_s      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_sum_s  = {1'b0, last_q} + (IW + 1)'(k);
            cand_s      = (cand_sum_s >= NUM_REQ_W) ? (cand_sum_s - NUM_REQ_W) : cand_sum_s;
            win_s       = (!win_valid_s && req[cand_s[IW-1:0]]) ? cand_s[IW-1:0] : win_s;
            win_valid_s = win_valid_s | req[cand_s[IW-1:0]];
        end
        win_onehot_s = ONE_HOT0 << win_s;
    end

    // Select the winning requester's command fields from the packed buses.
    always_comb begin
        sel_rw_s    = 1'b0;
        sel_chip_s  = 7'd0;
        sel_reg_s   = 8'd0;
        sel_wdata_s = 8'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_rw_s    = (win_s == IW'(i)) ? req_rw[i]              : sel_rw_s;
            sel_chip_s  = (win_s == IW'(i)) ? req_chip_addr[7*i +: 7] : sel_chip_s;
            sel_reg_s   = (win_s == IW'(i)) ? req_reg_addr[8*i +: 8]  : sel_reg_s;
            sel_wdata_s = (win_s == IW'(i)) ? req_wdata[8*i +: 8]     : sel_wdata_s;
        end
    end

    // Transaction sequencer: next-state and next-output computation.
    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        grant_d       = grant_q;
        done_d        = '0;
        err_d         = err_q;
        rdata_d       = rdata_q;
        m_start_d     = 1'b0;
        m_abort_d     = 1'b0;
        m_rw_d        = m_rw_q;
        m_chip_addr_d = m_chip_addr_q;
        m_reg_addr_d  = m_reg_addr_q;
        m_wdata_d     = m_wdata_q;
        tmo_cnt_d     = tmo_cnt_q;
        gap_cnt_d     = gap_cnt_q;

        case (state_q)
            S_IDLE: begin
                // Command fields are captured only here, so requester changes
                // during a transaction never reach the master.
                if (win_valid_s) begin
                    state_d       = S_ISSUE;
                    last_d        = win_s;
                    grant_d       = win_onehot_s;
                    m_rw_d        = sel_rw_s;
                    m_chip_addr_d = sel_chip_s;
                    m_reg_addr_d  = sel_reg_s;
                    m_wdata_d     = sel_wdata_s;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_ISSUE: begin
                m_start_d = 1'b1;
                tmo_cnt_d = 32'd0;
                state_d   = S_WAIT;
            end

            S_WAIT: begin
                // Completion is checked first so a m_done landing on the
                // watchdog's last cycle is reported normally, without abort.
                if (m_done) begin
                    done_d    = grant_q;
                    err_d     = m_ack_err;
                    rdata_d   = m_rw_q ? m_rdata : rdata_q;
                    grant_d   = '0;
                    gap_cnt_d = 32'd0;
                    state_d   = S_GAP;
                end else if (tmo_cnt_q >= TMO_LAST) begin
                    m_abort_d = 1'b1;
                    done_d    = grant_q;
                    err_d     = 1'b1;
                    grant_d   = '0;
                    gap_cnt_d = 32'd0;
                    state_d   = S_GAP;
                end else begin
                    tmo_cnt_d = (tmo_cnt_q != CNT_MAX) ? (tmo_cnt_q + 32'd1) : tmo_cnt_q;
                end
            end

            S_GAP: begin
                if (gap_cnt_q >= GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = (gap_cnt_q != CNT_MAX) ? (gap_cnt_q + 32'd1) : gap_cnt_q;
                end
            end

            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            last_q        <= LAST_RST;
            grant_q       <= '0;
            done_q        <= '0;
            err_q         <= 1'b0;
            rdata_q       <= 8'h00;
            busy_q        <= 1'b0;
            m_start_q     <= 1'b0;
            m_abort_q     <= 1'b0;
            m_rw_q        <= 1'b0;
            m_chip_addr_q <= 7'h00;
            m_reg_addr_q  <= 8'h00;
            m_wdata_q     <= 8'h00;
            tmo_cnt_q     <= 32'd0;
            gap_cnt_q     <= 32'd0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            grant_q       <= grant_d;
            done_q        <= done_d;
            err_q         <= err_d;
            rdata_q       <= rdata_d;
            busy_q        <= busy_d;
            m_start_q     <= m_start_d;
            m_abort_q     <= m_abort_d;
            m_rw_q        <= m_rw_d;
            m_chip_addr_q <= m_chip_addr_d;
            m_reg_addr_q  <= m_reg_addr_d;
            m_wdata_q     <= m_wdata_d;
            tmo_cnt_q     <= tmo_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
        end
    end

    assign grant       = grant_q;
    assign done        = done_q;
    assign err         = err_q;
    assign rdata       = rdata_q;
    assign busy        = busy_q;
    assign m_start     = m_start_q;
    assign m_abort     = m_abort_q;
    assign m_rw        = m_rw_q;
    assign m_chip_addr = m_chip_addr_q;
    assign m_reg_addr  = m_reg_addr_q;
    assign m_wdata     = m_wdata_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// ---------------------------------------------------------------------------
// Directed bench for i2c_bus_arbiter. Instance "dut" uses a 600-cycle gap and
// a long watchdog; instance "dut_t" uses a 4-cycle gap and a 50-cycle
// watchdog for the timeout scenarios. The bench plays the I2C master.
// ---------------------------------------------------------------------------
module tb_i2c_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req, req_rw;
    logic [13:0] req_chip_addr;
    logic [15:0] req_reg_addr, req_wdata;

    logic [1:0]  grant, done;
    logic        err, busy, m_start, m_rw, m_abort;
    logic [7:0]  rdata, m_reg_addr, m_wdata;
    logic [6:0]  m_chip_addr;
    logic        m_done, m_ack_err;
    logic [7:0]  m_rdata;

    logic [1:0]  t_req;
    logic [1:0]  t_grant, t_done;
    logic        t_err, t_busy, t_m_start, t_m_rw, t_m_abort;
    logic [7:0]  t_rdata, t_m_reg_addr, t_m_wdata;
    logic [6:0]  t_m_chip_addr;
    logic        t_m_done, t_m_ack_err;
    logic [7:0]  t_m_rdata;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    i2c_bus_arbiter #(.NUM_REQ(2), .GAP_CYCLES(600), .TIMEOUT_CYCLES(1000000)) dut (
        .clk(clk), .reset(reset), .req(req), .req_rw(req_rw),
        .req_chip_addr(req_chip_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
        .grant(grant), .done(done), .err(err), .rdata(rdata), .busy(busy),
        .m_start(m_start), .m_rw(m_rw), .m_chip_addr(m_chip_addr), .m_reg_addr(m_reg_addr),
        .m_wdata(m_wdata), .m_abort(m_abort), .m_done(m_done), .m_ack_err(m_ack_err),
        .m_rdata(m_rdata)
    );

    i2c_bus_arbiter #(.NUM_REQ(2), .GAP_CYCLES(4), .TIMEOUT_CYCLES(50)) dut_t (
        .clk(clk), .reset(reset), .req(t_req), .req_rw(req_rw),
        .req_chip_addr(req_chip_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
        .grant(t_grant), .done(t_done), .err(t_err), .rdata(t_rdata), .busy(t_busy),
        .m_start(t_m_start), .m_rw(t_m_rw), .m_chip_addr(t_m_chip_addr), .m_reg_addr(t_m_reg_addr),
        .m_wdata(t_m_wdata), .m_abort(t_m_abort), .m_done(t_m_done), .m_ack_err(t_m_ack_err),
        .m_rdata(t_m_rdata)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for m_start on the main instance.
    task automatic wait_start(input int budget, output int cycles, output bit ok);
        cycles = 0;
        ok = 1'b0;
        while (!ok && cycles < budget) begin
            tick();
            cycles++;
            if (m_start === 1'b1) ok = 1'b1;
        end
    endtask

    // Wait (bounded) for busy to fall on the main instance.
    task automatic wait_idle(input int budget, output bit ok);
        int c;
        c = 0;
        ok = (busy === 1'b0);
        while (!ok && c < budget) begin
            tick();
            c++;
            if (busy === 1'b0) ok = 1'b1;
        end
    endtask

    // Serve one transaction as the master: m_done lat cycles after m_start.
    task automatic run_txn(input int lat, input bit ack, input logic [7:0] rd,
                           output int wait_cyc, output bit ok, output logic [1:0] g,
                           output logic [1:0] d, output logic e, output logic [7:0] r);
        wait_start(3000, wait_cyc, ok);
        g = grant;
        d = 2'b00;
        e = 1'b0;
        r = 8'h00;
        if (ok) begin
            repeat (lat) tick();
            m_done = 1'b1; m_ack_err = ack; m_rdata = rd;
            tick();
            m_done = 1'b0; m_ack_err = 1'b0; m_rdata = 8'h00;
            d = done; e = err; r = rdata;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        tests++;
        if ({grant, done, err, rdata, busy, m_start, m_abort, m_rw, m_chip_addr, m_reg_addr, m_wdata} !== 45'd0) begin
            fails++;
            $display("FAIL reset_outputs: got grant=%b done=%b err=%b rdata=%h busy=%b start=%b abort=%b rw=%b chip=%h reg=%h wd=%h, want all zero",
                     grant, done, err, rdata, busy, m_start, m_abort, m_rw, m_chip_addr, m_reg_addr, m_wdata);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        int starts, early;
        req_chip_addr[6:0] = 7'h39; req_reg_addr[7:0] = 8'h41; req_wdata[7:0] = 8'h10;
        req_rw[0] = 1'b0; req[0] = 1'b1;
        tick();
        tests++; if (grant !== 2'b01) begin fails++; $display("FAIL wr_grant: got %b want 01", grant); end
        tests++; if (m_chip_addr !== 7'h39) begin fails++; $display("FAIL wr_chip: got %h want 39", m_chip_addr); end
        tests++; if (m_reg_addr !== 8'h41) begin fails++; $display("FAIL wr_reg: got %h want 41", m_reg_addr); end
        tests++; if (m_wdata !== 8'h10) begin fails++; $display("FAIL wr_wdata: got %h want 10", m_wdata); end
        tests++; if ({m_rw, m_start, busy} !== 3'b001) begin fails++; $display("FAIL wr_issue: got rw/start/busy=%b want 001", {m_rw, m_start, busy}); end
        tick();
        tests++; if (m_start !== 1'b1) begin fails++; $display("FAIL wr_start: got %b want 1", m_start); end
        starts = 1; early = 0;
        repeat (100) begin
            tick();
            if (m_start === 1'b1) starts++;
            if (done !== 2'b00) early++;
        end
        m_done = 1'b1; m_ack_err = 1'b0; m_rdata = 8'hEE;
        tick();
        m_done = 1'b0; m_rdata = 8'h00;
        tests++; if (starts !== 1) begin fails++; $display("FAIL wr_start_count: got %0d want 1", starts); end
        tests++; if (early !== 0) begin fails++; $display("FAIL wr_early_done: got %0d cycles want 0", early); end
        tests++; if ({done, err} !== 3'b010) begin fails++; $display("FAIL wr_done: got done/err=%b want 010", {done, err}); end
        tests++; if (rdata !== 8'h00) begin fails++; $display("FAIL wr_rdata_hold: got %h want 00", rdata); end
        tests++; if (grant !== 2'b00) begin fails++; $display("FAIL wr_grant_gap: got %b want 00", grant); end
        req[0] = 1'b0;
        repeat (599) tick();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL wr_gap_busy: got %b want 1", busy); end
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL wr_gap_end: got %b want 0", busy); end
    endtask

    task automatic test_read();
        int bad;
        bit ok;
        req_chip_addr[13:7] = 7'h4C; req_reg_addr[15:8] = 8'h42; req_wdata[15:8] = 8'h00;
        req_rw[1] = 1'b1; req[1] = 1'b1;
        tick();
        tests++; if (grant !== 2'b10) begin fails++; $display("FAIL rd_grant: got %b want 10", grant); end
        tests++; if ({m_rw, m_chip_addr, m_reg_addr} !== {1'b1, 7'h4C, 8'h42}) begin
            fails++; $display("FAIL rd_fields: got rw=%b chip=%h reg=%h want 1 4c 42", m_rw, m_chip_addr, m_reg_addr);
        end
        req_reg_addr[15:8] = 8'h99;
        bad = 0;
        repeat (21) begin
            tick();
            if (grant !== 2'b10) bad++;
        end
        m_done = 1'b1; m_rdata = 8'h5A; m_ack_err = 1'b0;
        tick();
        m_done = 1'b0; m_rdata = 8'h00;
        tests++; if (bad !== 0) begin fails++; $display("FAIL rd_grant_hold: got %0d bad cycles want 0", bad); end
        tests++; if ({done, err, rdata} !== {2'b10, 1'b0, 8'h5A}) begin
            fails++; $display("FAIL rd_done: got done=%b err=%b rdata=%h want 10 0 5a", done, err, rdata);
        end
        tests++; if (m_reg_addr !== 8'h42) begin fails++; $display("FAIL rd_latched: got %h want 42", m_reg_addr); end
        req[1] = 1'b0;
        req_reg_addr[15:8] = 8'h42;
        wait_idle(700, ok);
        tests++; if (!ok) begin fails++; $display("FAIL rd_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_contention();
        int wc;
        bit ok;
        logic [1:0] g, d, exp;
        logic e;
        logic [7:0] r;
        req_rw = 2'b00;
        reset = 1'b1;
        req = 2'b11;
        tick();
        reset = 1'b0;
        for (int t = 0; t < 4; t++) begin
            exp = (t % 2 == 0) ? 2'b01 : 2'b10;
            run_txn(5, 1'b0, 8'h33, wc, ok, g, d, e, r);
            tests++; if (!ok) begin fails++; $display("FAIL cont_start[%0d]: no m_start within %0d cycles", t, wc); end
            tests++; if (g !== exp) begin fails++; $display("FAIL cont_grant[%0d]: got %b want %b", t, g, exp); end
            tests++; if ({d, e} !== {exp, 1'b0}) begin fails++; $display("FAIL cont_done[%0d]: got done=%b err=%b want %b 0", t, d, e, exp); end
        end
    endtask

    task automatic test_nack();
        int wc;
        bit ok;
        logic [1:0] g, d;
        logic e;
        logic [7:0] r;
        run_txn(7, 1'b1, 8'h77, wc, ok, g, d, e, r);
        tests++; if (!ok || g !== 2'b01) begin fails++; $display("FAIL nack_grant: got ok=%b grant=%b want 1 01", ok, g); end
        tests++; if ({d, e, r} !== {2'b01, 1'b1, 8'h00}) begin
            fails++; $display("FAIL nack_done: got done=%b err=%b rdata=%h want 01 1 00", d, e, r);
        end
        run_txn(3, 1'b0, 8'h00, wc, ok, g, d, e, r);
        tests++; if (wc !== 602) begin fails++; $display("FAIL nack_gap: got %0d cycles to next start want 602", wc); end
        tests++; if ({g, d, e} !== {2'b10, 2'b10, 1'b0}) begin
            fails++; $display("FAIL nack_next: got grant=%b done=%b err=%b want 10 10 0", g, d, e);
        end
        req = 2'b00;
        wait_idle(700, ok);
        tests++; if (!ok) begin fails++; $display("FAIL nack_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_timeout();
        int c, aborts;
        bit seen;
        // Master never answers: abort exactly 50 cycles after m_start.
        t_req = 2'b01;
        seen = 1'b0; c = 0;
        while (!seen && c < 10) begin tick(); c++; if (t_m_start === 1'b1) seen = 1'b1; end
        tests++; if (!seen) begin fails++; $display("FAIL to_start: got no m_start want one"); end
        seen = 1'b0; c = 0;
        while (!seen && c < 100) begin tick(); c++; if (t_m_abort === 1'b1) seen = 1'b1; end
        tests++; if (c !== 50 || !seen) begin fails++; $display("FAIL to_abort_time: got %0d cycles want 50", c); end
        tests++; if ({t_done, t_err, t_rdata} !== {2'b01, 1'b1, 8'h00}) begin
            fails++; $display("FAIL to_done: got done=%b err=%b rdata=%h want 01 1 00", t_done, t_err, t_rdata);
        end
        t_req = 2'b00;
        tick();
        tests++; if (t_m_abort !== 1'b0) begin fails++; $display("FAIL to_abort_pulse: got %b want 0", t_m_abort); end
        repeat (10) tick();
        // m_done lands on the watchdog's final cycle: completion wins.
        req_rw = 2'b10;
        t_req = 2'b10;
        seen = 1'b0; c = 0;
        while (!seen && c < 10) begin tick(); c++; if (t_m_start === 1'b1) seen = 1'b1; end
        tests++; if (!seen || t_grant !== 2'b10) begin fails++; $display("FAIL to2_start: got start=%b grant=%b want 1 10", seen, t_grant); end
        repeat (49) tick();
        t_m_done = 1'b1; t_m_ack_err = 1'b0; t_m_rdata = 8'hC3;
        tick();
        t_m_done = 1'b0; t_m_rdata = 8'h00;
        tests++; if ({t_done, t_err, t_m_abort, t_rdata} !== {2'b10, 1'b0, 1'b0, 8'hC3}) begin
            fails++; $display("FAIL to2_done: got done=%b err=%b abort=%b rdata=%h want 10 0 0 c3", t_done, t_err, t_m_abort, t_rdata);
        end
        t_req = 2'b00;
        aborts = 0;
        repeat (5) begin tick(); if (t_m_abort !== 1'b0) aborts++; end
        tests++; if (aborts !== 0) begin fails++; $display("FAIL to2_no_abort: got %0d abort cycles want 0", aborts); end
        req_rw = 2'b00;
    endtask

    task automatic test_reset_mid_wait();
        int wc;
        bit ok;
        logic [1:0] g, d;
        logic e;
        logic [7:0] r;
        req = 2'b01;
        wait_start(10, wc, ok);
        tests++; if (!ok || grant !== 2'b01) begin fails++; $display("FAIL rst_pre: got start=%b grant=%b want 1 01", ok, grant); end
        req = 2'b11;
        repeat (20) tick();
        reset = 1'b1;
        #1;
        tests++;
        if ({grant, done, err, rdata, busy, m_start, m_abort, m_rw, m_chip_addr, m_reg_addr, m_wdata} !== 45'd0) begin
            fails++;
            $display("FAIL rst_mid_outputs: got grant=%b busy=%b chip=%h reg=%h wd=%h, want all zero",
                     grant, busy, m_chip_addr, m_reg_addr, m_wdata);
        end
        tick();
        tick();
        reset = 1'b0;
        run_txn(4, 1'b0, 8'h00, wc, ok, g, d, e, r);
        tests++; if (!ok || g !== 2'b01 || d !== 2'b01) begin
            fails++; $display("FAIL rst_winner: got start=%b grant=%b done=%b want 1 01 01", ok, g, d);
        end
        req = 2'b00;
        wait_idle(700, ok);
        tests++; if (!ok) begin fails++; $display("FAIL rst_idle: got busy=%b want 0", busy); end
    endtask

    initial begin
        reset = 1'b1;
        req = 2'b00; req_rw = 2'b00;
        req_chip_addr = 14'd0; req_reg_addr = 16'd0; req_wdata = 16'd0;
        m_done = 1'b0; m_ack_err = 1'b0; m_rdata = 8'h00;
        t_req = 2'b00; t_m_done = 1'b0; t_m_ack_err = 1'b0; t_m_rdata = 8'h00;

        test_reset();
        test_single_write();
        test_read();
        test_contention();
        test_nack();
        test_timeout();
        test_reset_mid_wait();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
